serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Built from one full-subtractor cell and a borrow flip-flop; the arithmetic dual of the team's full-adder cells.
- Used where area matters more than throughput, e.g. compare/decrement paths in slow control datapaths.
- Start/done handshake; results held stable until the next operation.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // clog2 with a floor of 1 so a WIDTH=1 instance still gets a real counter bit
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Results are registered on entry to DONE and held until the next DONE.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shift;

    full_subtractor_cell u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    assign res_shift = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_shift;
                br_d   = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_shift;
                    borrow_d = cell_bout;
                    ovf_d    = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst8, rst1;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       ready8, busy8, done8, br8, ovf8;
    logic [7:0] diff8;
    logic       ready1, busy1, done1, br1, ovf1;
    logic [0:0] diff1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(br8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1),
        .borrow_out(br1), .overflow(ovf1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one op on the WIDTH=8 instance and check latency and results
    task automatic run_op8(input logic [7:0] a_v, input logic [7:0] b_v,
                           input logic [7:0] e_diff, input logic e_br, input logic e_ovf);
        int n;
        @(negedge clk);
        start8 = 1'b1; a8 = a_v; b8 = b_v;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~a_v; b8 = ~b_v;
        check_eq("w8 busy after accept", busy8, 1);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("w8 latency", n, 8);
        check_eq("w8 diff", diff8, e_diff);
        check_eq("w8 borrow", br8, e_br);
        check_eq("w8 overflow", ovf8, e_ovf);
        check_eq("w8 ready in done", ready8, 0);
        @(negedge clk);
        check_eq("w8 done one cycle", done8, 0);
        check_eq("w8 ready after done", ready8, 1);
        check_eq("w8 diff held", diff8, e_diff);
    endtask

    task automatic run_op1(input logic a_v, input logic b_v,
                           input logic e_diff, input logic e_br, input logic e_ovf);
        int n;
        @(negedge clk);
        start1 = 1'b1; a1 = a_v; b1 = b_v;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; a1 = ~a_v; b1 = ~b_v;
        n = 0;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("w1 latency", n, 1);
        check_eq("w1 diff", diff1, e_diff);
        check_eq("w1 borrow", br1, e_br);
        check_eq("w1 overflow", ovf1, e_ovf);
        @(negedge clk);
        check_eq("w1 ready after done", ready1, 1);
    endtask

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ea, eb;
        int last_done, n_done, n_busy;

        rst8 = 1'b1; rst1 = 1'b1;
        start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        #12;
        check_eq("rst ready", ready8, 1);
        check_eq("rst busy", busy8, 0);
        check_eq("rst done", done8, 0);
        check_eq("rst diff", diff8, 0);
        check_eq("rst borrow", br8, 0);
        check_eq("rst overflow", ovf8, 0);
        @(negedge clk);
        rst8 = 1'b0; rst1 = 1'b0;

        run_op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op8(8'h23, 8'h5A, 8'hC9, 1'b1, 1'b0);
        run_op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start held high, operands changing every cycle
        last_done = -1;
        n_done    = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done8) begin
                if (qa.size() == 0) begin
                    check_eq("stream spurious done", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    check_eq("stream diff", diff8, 8'(ea - eb));
                    check_eq("stream borrow", br8, (ea < eb) ? 1 : 0);
                end
                if (last_done >= 0) check_eq("stream period", i - last_done, 10);
                last_done = i;
                n_done++;
            end
            start8 = 1'b1;
            a8 = 8'(i * 37 + 5);
            b8 = 8'(i * 91 + 3);
            if (ready8) begin
                qa.push_back(a8);
                qb.push_back(b8);
            end
        end
        check_eq("stream op count", n_done, 4);
        // let the in-flight op drain so the next test starts from IDLE
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        check_eq("stream drained", ready8, 1);

        // reset during the 4th SHIFT cycle
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        n_busy = 1;
        while (n_busy < 4) begin
            @(negedge clk);
            n_busy++;
        end
        check_eq("abort busy before rst", busy8, 1);
        rst8 = 1'b1;
        #1;
        check_eq("abort ready", ready8, 1);
        check_eq("abort busy", busy8, 0);
        check_eq("abort diff", diff8, 0);
        check_eq("abort borrow", br8, 0);
        check_eq("abort overflow", ovf8, 0);
        @(negedge clk);
        rst8 = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        check_eq("abort no done", n_done, 0);
        run_op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        run_op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
